// File: rtl/buzzer_driver.sv
// buzzer_driver: piezo buzzer sequencer for alarm and hourly-chime events.
// A rising edge on start plays BEEP_COUNT square-wave bursts separated by
// silent gaps, all timed from a 1 us tick enable derived from clk_100MHz.
// A high level on stop aborts a running sequence.
// Optional feature: define BUZZER_DUAL_TONE_EN to play odd-numbered bursts
// at TONE_B_HALF_US instead of TONE_HALF_US (two-tone alarm).
module buzzer_driver #(
  parameter int unsigned CLK_DIV        = 100,
  parameter int unsigned TONE_HALF_US   = 250,
  parameter int unsigned TONE_B_HALF_US = 190,
  parameter int unsigned BEEP_ON_US     = 200_000,
  parameter int unsigned BEEP_OFF_US    = 200_000,
  parameter int unsigned BEEP_COUNT     = 3
) (
  input  logic clk_100MHz,
  input  logic rst_buzzer,
  input  logic start,
  input  logic stop,
  output logic buzzer_out,
  output logic busy,
  output logic done
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [31:0] ON_LAST  = 32'(BEEP_ON_US - 1);
  localparam logic [31:0] OFF_LAST = 32'(BEEP_OFF_US - 1);
  localparam logic [7:0]  IDX_LAST = 8'(BEEP_COUNT - 1);

`ifdef BUZZER_DUAL_TONE_EN
  localparam bit DUAL_TONE = 1'b1;
`else
  localparam bit DUAL_TONE = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    TONE,
    GAP
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic             start_d;
  logic             start_edge;
  logic [31:0]      dur_cnt;
  logic [31:0]      tone_cnt;
  logic [31:0]      half_last;
  logic [7:0]       beep_idx;

  // Terminal tone_cnt value for a burst; odd bursts use the second pitch
  // only when the two-tone feature is built in.
  function automatic logic [31:0] half_last_for(input logic [7:0] idx);
    if (DUAL_TONE && idx[0]) begin
      return 32'(TONE_B_HALF_US - 1);
    end
    return 32'(TONE_HALF_US - 1);
  endfunction

  assign tick       = (div_cnt == DIV_LAST);
  assign start_edge = start & ~start_d;

  // Free-running 1 us tick divider; its phase is never disturbed by start.
  always_ff @(posedge clk_100MHz or negedge rst_buzzer) begin
    if (!rst_buzzer) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Delayed copy of start for rising-edge detection.
  always_ff @(posedge clk_100MHz or negedge rst_buzzer) begin
    if (!rst_buzzer) begin
      start_d <= 1'b0;
    end else begin
      start_d <= start;
    end
  end

  // Beep sequencer: IDLE -> (TONE -> GAP) x BEEP_COUNT -> IDLE, stop aborts.
  always_ff @(posedge clk_100MHz or negedge rst_buzzer) begin
    if (!rst_buzzer) begin
      state      <= IDLE;
      dur_cnt    <= '0;
      tone_cnt   <= '0;
      beep_idx   <= '0;
      half_last  <= half_last_for(8'd0);
      buzzer_out <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state      <= IDLE;
        dur_cnt    <= '0;
        tone_cnt   <= '0;
        beep_idx   <= '0;
        buzzer_out <= 1'b0;
        busy       <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start_edge) begin
              state      <= TONE;
              dur_cnt    <= '0;
              tone_cnt   <= '0;
              beep_idx   <= '0;
              half_last  <= half_last_for(8'd0);
              buzzer_out <= 1'b0;
              busy       <= 1'b1;
            end
          end
          TONE: begin
            if (tick) begin
              if (dur_cnt == ON_LAST) begin
                // Burst end overrides a toggle landing on the same tick.
                state      <= GAP;
                dur_cnt    <= '0;
                buzzer_out <= 1'b0;
              end else begin
                dur_cnt <= dur_cnt + 32'd1;
                if (tone_cnt == half_last) begin
                  buzzer_out <= ~buzzer_out;
                  tone_cnt   <= '0;
                end else begin
                  tone_cnt <= tone_cnt + 32'd1;
                end
              end
            end
          end
          GAP: begin
            buzzer_out <= 1'b0;
            if (tick) begin
              if (dur_cnt == OFF_LAST) begin
                dur_cnt <= '0;
                if (beep_idx == IDX_LAST) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                end else begin
                  state     <= TONE;
                  beep_idx  <= beep_idx + 8'd1;
                  tone_cnt  <= '0;
                  half_last <= half_last_for(beep_idx + 8'd1);
                end
              end else begin
                dur_cnt <= dur_cnt + 32'd1;
              end
            end
          end
          default: begin
            state      <= IDLE;
            buzzer_out <= 1'b0;
            busy       <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_buzzer_driver.sv
// tb_buzzer_driver: randomized bench for buzzer_driver with a reference model
// that derives expected outputs from the number of ticks elapsed since start.
module tb_buzzer_driver;

  localparam int CLK_DIV     = 4;
  localparam int TONE_HALF   = 2;
  localparam int TONE_B_HALF = 1;
  localparam int ON_T        = 8;
  localparam int OFF_T       = 4;
  localparam int COUNT       = 2;
  localparam int PERIOD      = ON_T + OFF_T;

`ifdef BUZZER_DUAL_TONE_EN
  localparam bit DUAL = 1'b1;
`else
  localparam bit DUAL = 1'b0;
`endif

  logic clk_100MHz = 1'b0;
  logic rst_buzzer = 1'b0;
  logic start      = 1'b0;
  logic stop       = 1'b0;
  logic buzzer_out;
  logic busy;
  logic done;

  int errors = 0;
  int checks = 0;

  // Reference model state: clock edges since reset release, ticks since start.
  int m_k      = 0;
  int m_j      = 0;
  bit m_active = 1'b0;
  bit m_done   = 1'b0;
  bit m_prev   = 1'b0;
  int done_seen = 0;

  buzzer_driver #(
    .CLK_DIV       (CLK_DIV),
    .TONE_HALF_US  (TONE_HALF),
    .TONE_B_HALF_US(TONE_B_HALF),
    .BEEP_ON_US    (ON_T),
    .BEEP_OFF_US   (OFF_T),
    .BEEP_COUNT    (COUNT)
  ) dut (
    .clk_100MHz(clk_100MHz),
    .rst_buzzer(rst_buzzer),
    .start     (start),
    .stop      (stop),
    .buzzer_out(buzzer_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Expected pin level: burst b = j/PERIOD, position r = j%PERIOD; during the
  // tone part the pin has toggled r/half times starting from low.
  function automatic logic exp_out();
    int b;
    int r;
    int h;
    if (!m_active) return 1'b0;
    b = m_j / PERIOD;
    r = m_j % PERIOD;
    h = (DUAL && (b % 2 == 1)) ? TONE_B_HALF : TONE_HALF;
    if (r >= ON_T) return 1'b0;
    return ((r / h) % 2) == 1;
  endfunction

  task automatic model_reset();
    m_k      = 0;
    m_j      = 0;
    m_active = 1'b0;
    m_done   = 1'b0;
    m_prev   = 1'b0;
  endtask

  // One clock: advance the model with the inputs seen at the edge, then compare.
  task automatic step();
    bit tick;
    bit rise;
    @(posedge clk_100MHz);
    tick   = (m_k % CLK_DIV) == (CLK_DIV - 1);
    rise   = start && !m_prev;
    m_prev = start;
    m_done = 1'b0;
    if (stop) begin
      m_active = 1'b0;
    end else if (!m_active) begin
      if (rise) begin
        m_active = 1'b1;
        m_j      = 0;
      end
    end else if (tick) begin
      m_j++;
      if (m_j == COUNT * PERIOD) begin
        m_active = 1'b0;
        m_done   = 1'b1;
      end
    end
    m_k++;
    #1;
    check("busy", busy, m_active);
    check("buzzer_out", buzzer_out, exp_out());
    check("done", done, m_done);
    if (done) done_seen++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Assert reset between edges, check outputs clear at once, release later.
  task automatic mid_reset(input string tag);
    #2;
    rst_buzzer = 1'b0;
    #1;
    check({tag, "_out"}, buzzer_out, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    @(posedge clk_100MHz);
    #2;
    rst_buzzer = 1'b1;
    model_reset();
  endtask

  initial begin
    // Reset state.
    repeat (3) @(posedge clk_100MHz);
    #1;
    check("rst_out", buzzer_out, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    @(negedge clk_100MHz);
    rst_buzzer = 1'b1;
    model_reset();
    steps(2);

    // Nominal sequence with a random tick phase; start held past the end.
    steps($urandom_range(0, 7));
    done_seen = 0;
    start = 1'b1;
    step();
    check("nom_busy_latency", busy, 1'b1);
    steps(110);
    check("nom_done_count", done_seen, 1);
    check("nom_no_restart", busy, 1'b0);
    start = 1'b0;
    steps(3);

    // Stop during the first burst: no done pulse.
    steps($urandom_range(0, 7));
    done_seen = 0;
    start = 1'b1;
    steps($urandom_range(6, 28));
    stop = 1'b1;
    step();
    check("stop_busy", busy, 1'b0);
    check("stop_out", buzzer_out, 1'b0);
    stop = 1'b0;
    steps(110);
    check("stop_done_count", done_seen, 0);
    start = 1'b0;
    steps(2);

    // Second start edge while busy is ignored.
    done_seen = 0;
    start = 1'b1;
    steps(30);
    start = 1'b0;
    steps(10);
    start = 1'b1;
    steps(80);
    check("retrig_done_count", done_seen, 1);
    start = 1'b0;
    steps(2);

    // Start edge together with stop in IDLE.
    start = 1'b1;
    stop  = 1'b1;
    step();
    stop = 1'b0;
    steps(5);
    check("simul_busy", busy, 1'b0);
    start = 1'b0;
    steps(2);

    // Reset in the middle of a tone burst.
    start = 1'b1;
    steps(14);
    mid_reset("midrst");
    start = 1'b0;
    steps(110);

    // Randomized start/stop/reset activity.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 23) == 0) start = ~start;
      stop = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 799) == 0) mid_reset("rnd_rst");
      step();
    end
    stop = 1'b0;
    start = 1'b0;
    steps(120);
    check("final_idle", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
